// File: rtl/dl_lshift_arb_pkg.sv
// rtl/dl_lshift_arb_pkg.sv - shared width helpers and defaults for the shared left-shift arbiter
package dl_lshift_arb_pkg;

    localparam int DEFAULT_NUM_BITS = 32;
    localparam int DEFAULT_NUM_REQ  = 4;

    // Index width for n items; never below 1 so degenerate widths still elaborate.
    function automatic int idx_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dl_lshift.sv
// rtl/dl_lshift.sv - zero-filling logical left shift, result truncated to operand width
module dl_lshift
    import dl_lshift_arb_pkg::*;
#(
    parameter  int NUM_BITS       = DEFAULT_NUM_BITS,
    localparam int NUM_SHIFT_BITS = idx_bits(NUM_BITS)
) (
    input  logic [NUM_BITS-1:0]       a,
    input  logic [NUM_SHIFT_BITS-1:0] shift,
    output logic [NUM_BITS-1:0]       y
);

    assign y = a << shift;

endmodule

// File: rtl/dl_rr_arb.sv
// rtl/dl_rr_arb.sv - combinational round-robin arbiter: first requester at or after ptr wins
module dl_rr_arb
    import dl_lshift_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int ID_BITS = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_BITS-1:0] gnt_id
);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/dl_lshift_arb.sv
// rtl/dl_lshift_arb.sv - round-robin sharing of one left shifter with a one-entry response slot
module dl_lshift_arb
    import dl_lshift_arb_pkg::*;
#(
    parameter  int NUM_BITS       = DEFAULT_NUM_BITS,
    parameter  int NUM_REQ        = DEFAULT_NUM_REQ,
    localparam int NUM_SHIFT_BITS = idx_bits(NUM_BITS),
    localparam int ID_BITS        = idx_bits(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*NUM_BITS-1:0]       req_a,
    input  logic [NUM_REQ*NUM_SHIFT_BITS-1:0] req_shift,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [NUM_BITS-1:0]               resp_data,
    output logic [ID_BITS-1:0]                resp_id
);

    logic                      resp_valid_q, resp_valid_d;
    logic [NUM_BITS-1:0]       resp_data_q,  resp_data_d;
    logic [ID_BITS-1:0]        resp_id_q,    resp_id_d;
    logic [ID_BITS-1:0]        rr_ptr_q,     rr_ptr_d;

    logic                      slot_free;
    logic                      arb_en;
    logic [NUM_REQ-1:0]        gnt;
    logic [ID_BITS-1:0]        gnt_id;
    logic                      xfer;
    logic [NUM_BITS-1:0]       sel_a;
    logic [NUM_SHIFT_BITS-1:0] sel_shift;
    logic [NUM_BITS-1:0]       shifted;

    // Draining and refilling the slot in the same cycle keeps one result per cycle.
    assign slot_free = !resp_valid_q || resp_ready;
    assign arb_en    = slot_free && !rst;

    dl_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_comb begin
        sel_a     = req_a[int'(gnt_id)*NUM_BITS +: NUM_BITS];
        sel_shift = req_shift[int'(gnt_id)*NUM_SHIFT_BITS +: NUM_SHIFT_BITS];
    end

    dl_lshift #(
        .NUM_BITS (NUM_BITS)
    ) u_lshift (
        .a     (sel_a),
        .shift (sel_shift),
        .y     (shifted)
    );

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (xfer) begin
            resp_valid_d = 1'b1;
            resp_data_d  = shifted;
            resp_id_d    = gnt_id;
            rr_ptr_d     = (gnt_id == ID_BITS'(NUM_REQ - 1)) ? '0 : gnt_id + ID_BITS'(1);
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_dl_lshift_arb.sv
// tb/tb_dl_lshift_arb.sv - scoreboard bench for dl_lshift_arb with a behavioural reference model
module tb_dl_lshift_arb;

    localparam int NB = 32;
    localparam int NR = 4;
    localparam int SB = 5;
    localparam int IB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*NB-1:0]  req_a;
    logic [NR*SB-1:0]  req_shift;
    logic              resp_valid;
    logic              resp_ready;
    logic [NB-1:0]     resp_data;
    logic [IB-1:0]     resp_id;

    dl_lshift_arb #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_shift  (req_shift),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] data;
        int            id;
    } resp_t;

    resp_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_ptr   = 0;
    bit          m_valid = 1'b0;
    int          last_gnt = -1;
    logic [NB-1:0] a_val [NR];
    logic [SB-1:0] sh_val[NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift as multiplication by a power of two, wrapped to NB bits.
    function automatic logic [NB-1:0] ref_shift(input logic [NB-1:0] a, input int sh);
        logic [63:0] p;
        p = 64'(a) * (64'd1 << sh);
        return p[NB-1:0];
    endfunction

    function automatic int ref_grant(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // One clock of stimulus; checks handshake outputs and advances the model.
    task automatic drive_cycle(input logic [NR-1:0] v, input logic rr);
        int g;
        logic [NR-1:0] exp_rdy;
        resp_t e;
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = v;
        resp_ready = rr;
        for (int i = 0; i < NR; i++) begin
            req_a[i*NB +: NB]     = a_val[i];
            req_shift[i*SB +: SB] = sh_val[i];
        end
        #1;
        g = (!m_valid || rr) ? ref_grant(v, m_ptr) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        if (g >= 0) begin
            e.data = ref_shift(a_val[g], int'(sh_val[g]));
            e.id   = g;
            exp_q.push_back(e);
            m_ptr    = (g + 1) % NR;
            m_valid  = 1'b1;
            last_gnt = g;
        end else if (rr) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst        = 1'b1;
            req_valid  = '1;
            resp_ready = 1'b0;
            #1;
            chk("rst_req_ready", 64'(req_ready), 64'd0);
        end
        m_valid = 1'b0;
        m_ptr   = 0;
        exp_q.delete();
    endtask

    // Monitor: compares the presented response to the queue head; pops on handshake.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    if (resp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0; req_a = '0; req_shift = '0;
        for (int i = 0; i < NR; i++) begin a_val[i] = '0; sh_val[i] = '0; end

        reset_cycles(3);
        @(negedge clk);
        rst = 1'b0; req_valid = '0; #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);

        // Single request
        a_val[0] = 32'h0000_00F1; sh_val[0] = 5'd4;
        drive_cycle(4'b0001, 1'b1);
        drive_cycle(4'b0000, 1'b0);
        chk("single_data", 64'(resp_data), 64'h0000_0F10);
        chk("single_id", 64'(resp_id), 64'd0);
        drive_cycle(4'b0000, 1'b1);

        // Fairness: all valid continuously
        for (int i = 0; i < NR; i++) begin a_val[i] = 32'h11 * (i + 1); sh_val[i] = 5'(i); end
        for (int c = 0; c < 9; c++) begin
            drive_cycle(4'b1111, 1'b1);
            chk("fair_order", 64'(last_gnt), 64'((c + 1) % NR));
        end

        // Backpressure for 5 cycles, then release
        for (int c = 0; c < 5; c++) drive_cycle(4'b1111, 1'b0);
        drive_cycle(4'b1111, 1'b1);
        chk("bp_next_grant", 64'(last_gnt), 64'((NR + 2) % NR));
        drive_cycle(4'b0000, 1'b1);
        drive_cycle(4'b0000, 1'b1);

        // Boundary shifts
        a_val[1] = 32'hFFFF_FFFF; sh_val[1] = 5'd31;
        drive_cycle(4'b0010, 1'b1);
        drive_cycle(4'b0000, 1'b0);
        chk("shift31", 64'(resp_data), 64'h8000_0000);
        a_val[1] = 32'hFFFF_FFFF; sh_val[1] = 5'd0;
        drive_cycle(4'b0010, 1'b1);
        drive_cycle(4'b0000, 1'b0);
        chk("shift0", 64'(resp_data), 64'hFFFF_FFFF);

        // Pointer to 3, then only req0 valid -> wraps
        drive_cycle(4'b0100, 1'b1);
        drive_cycle(4'b0001, 1'b1);
        chk("wrap_grant", 64'(last_gnt), 64'd0);
        drive_cycle(4'b0000, 1'b1);

        // Reset mid-stream with a stalled response
        drive_cycle(4'b0100, 1'b1);
        drive_cycle(4'b0000, 1'b0);
        reset_cycles(1);
        @(negedge clk);
        rst = 1'b0; req_valid = '0; resp_ready = 1'b1; #1;
        chk("rst_mid_valid", 64'(resp_valid), 64'd0);
        drive_cycle(4'b1010, 1'b1);
        chk("rst_ptr_search", 64'(last_gnt), 64'd1);
        drive_cycle(4'b0000, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                a_val[i]  = $urandom;
                sh_val[i] = 5'($urandom_range(0, NB - 1));
            end
            drive_cycle(4'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 4; c++) drive_cycle(4'b0000, 1'b1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
